// File: rtl/instr_mem_debug_master_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_debug_master_pkg
// Shared definitions for the instruction-memory debug master:
//   - FSM state encoding
//   - fixed field widths (word address, data, burst length)
//   - the 16 KiB access window test (byte addr[31:14] == 0)
// ---------------------------------------------------------------------------
package instr_mem_debug_master_pkg;

    localparam int ADDR_W = 30;   // word address, byte address bits [31:2]
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;    // extra read beats (burst length - 1)

    // Byte address bit 14 is word address bit 12; everything from there up
    // must be zero for an access to land inside the 16 KiB window.
    localparam int WIN_LSB = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:WIN_LSB] == '0;
    endfunction

endpackage

// File: rtl/instr_mem_debug_master.sv
// ---------------------------------------------------------------------------
// instr_mem_debug_master
// Host-side debug port onto port b of an instruction RAM. Accepts one
// request at a time (read or write), drives the RAM, and returns one
// response beat per word. Addresses outside the 16 KiB window never reach
// the RAM as writes and come back with resp_err=1, resp_rdata=0.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we/addr/wdata   request fields, latched on handshake
//   req_len             extra read beats (used only with DEBUG_BURST_EN)
//   resp_valid/ready    response handshake; outputs held until accepted
//   resp_rdata/err/last response beat contents
//   ram_web/addrb/dinb  RAM port-b controls
//   ram_doutb           RAM port-b read data, one cycle after address
//
// Configuration
//   DEBUG_BURST_EN      when defined, reads return req_len+1 beats at
//                       consecutive word addresses (mod 2^30). Otherwise
//                       every read is a single beat with resp_last=1.
// ---------------------------------------------------------------------------
module instr_mem_debug_master
    import instr_mem_debug_master_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_last,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic [DATA_W-1:0] ram_dinb,
    input  logic [DATA_W-1:0] ram_doutb
);

`ifdef DEBUG_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    state_t            state;
    logic [ADDR_W-1:0] addr_q;   // address of the beat in flight
    logic [LEN_W-1:0]  cnt_q;    // read beats still owed after this one

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_last  <= 1'b0;
            ram_web    <= 1'b0;
            ram_addrb  <= '0;
            ram_dinb   <= '0;
        end else begin
            // Write strobe is a single-cycle pulse raised only on entry to WRITE.
            ram_web <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        ram_addrb <= req_addr;
                        if (req_we) begin
                            state    <= ST_WRITE;
                            ram_web  <= in_window(req_addr);
                            ram_dinb <= req_wdata;
                            cnt_q    <= '0;
                        end else begin
                            state <= ST_RD_ADDR;
                            cnt_q <= req_len & {LEN_W{BURST_EN}};
                        end
                    end
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= ~in_window(addr_q);
                    resp_last  <= 1'b1;
                end
                ST_RD_ADDR: begin
                    // RAM registers ram_addrb on this edge; data shows next cycle.
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= in_window(addr_q) ? ram_doutb : '0;
                    resp_err   <= ~in_window(addr_q);
                    resp_last  <= (cnt_q == '0);
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (cnt_q != '0) begin
                            // Next burst beat; each beat gets its own window check.
                            cnt_q     <= cnt_q - 1'b1;
                            addr_q    <= addr_q + 1'b1;
                            ram_addrb <= addr_q + 1'b1;
                            state     <= ST_RD_ADDR;
                        end else begin
                            state     <= ST_IDLE;
                            req_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_debug_master.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_debug_master
// Drives directed and random requests into instr_mem_debug_master with a
// behavioural RAM on port b, and compares every response beat against a
// shadow copy of memory computed from the window / burst rules.
// ---------------------------------------------------------------------------
module tb_instr_mem_debug_master;

`ifdef DEBUG_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  req_len;
    logic        resp_valid, resp_ready, resp_err, resp_last;
    logic [31:0] resp_rdata;
    logic        ram_web;
    logic [29:0] ram_addrb;
    logic [31:0] ram_dinb;
    logic [31:0] ram_doutb;

    always #5 clk = ~clk;

    instr_mem_debug_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_last(resp_last),
        .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb),
        .ram_doutb(ram_doutb)
    );

    // 16 KiB synchronous RAM (4096 words), one-cycle read latency.
    bit [31:0] mem    [4096];
    bit [31:0] shadow [4096];   // reference view of memory contents
    int          web_cnt = 0;
    logic [29:0] web_addr;
    logic [31:0] web_data;

    always @(posedge clk) begin
        if (ram_web === 1'b1) begin
            mem[ram_addrb[11:0]] <= ram_dinb;
            web_cnt  <= web_cnt + 1;
            web_addr <= ram_addrb;
            web_data <= ram_dinb;
        end
        ram_doutb <= mem[ram_addrb[11:0]];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [29:0] rnd_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return 30'($urandom_range(0, 15));
            1:       return 30'($urandom_range(0, 4095));
            2:       return 30'(32'hFFC + $urandom_range(0, 8));
            3:       return r[29:0] | 30'h1000;
            default: return 30'(32'h3FFF_FFFC + $urandom_range(0, 3));
        endcase
    endfunction

    // One full transaction: handshake, every response beat, memory effect.
    task automatic do_req(input logic we, input logic [29:0] addr,
                          input logic [31:0] wd, input logic [7:0] len,
                          input int stall);
        int          nb, lat, wc0;
        logic [29:0] a;
        logic [31:0] exp_d, hold_d;
        logic        ok, hold_e;
        nb = we ? 1 : (BURST ? int'(len) + 1 : 1);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 1);
        wc0       = web_cnt;
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wd;   req_len = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            a     = addr + 30'(b);
            ok    = (a < 30'h1000);
            exp_d = (we || !ok) ? 32'h0 : shadow[a[11:0]];
            lat   = 1;
            while (resp_valid !== 1'b1 && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            chk("latency", 32'(lat), we ? 2 : 3);
            chk("rdata", resp_rdata, exp_d);
            chk("err", 32'(resp_err), 32'(!ok));
            chk("last", 32'(resp_last), 32'(b == nb - 1));
            hold_d = resp_rdata; hold_e = resp_err;
            for (int s = 0; s < stall; s++) begin
                // Stray request while busy must be ignored.
                req_valid = 1'b1; req_we = 1'b1;
                req_addr  = rnd_addr(); req_wdata = $urandom;
                @(posedge clk); #1;
                chk("hold_valid", 32'(resp_valid), 1);
                chk("hold_rdata", resp_rdata, hold_d);
                chk("hold_err", 32'(resp_err), 32'(hold_e));
                chk("busy_ready", 32'(req_ready), 0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
        chk("done_valid", 32'(resp_valid), 0);
        chk("done_ready", 32'(req_ready), 1);
        if (we) begin
            ok = (addr < 30'h1000);
            chk("web_pulses", 32'(web_cnt - wc0), 32'(ok));
            if (ok) begin
                chk("web_addr", 32'(web_addr), 32'(addr));
                chk("web_data", web_data, wd);
                shadow[addr[11:0]] = wd;
            end
        end else begin
            chk("rd_no_web", 32'(web_cnt - wc0), 0);
        end
    endtask

    initial begin
        int wc0, seen;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_len = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", 32'(resp_err), 0);
        chk("rst_last", 32'(resp_last), 0);
        chk("rst_web", 32'(ram_web), 0);
        chk("rst_addrb", 32'(ram_addrb), 0);
        chk("rst_dinb", ram_dinb, 0);
        rst_n = 1'b1;

        // Directed cases
        do_req(1'b1, 30'h10, 32'hDEAD_BEEF, 8'd0, 0);
        do_req(1'b1, 30'h5, 32'h1234_5678, 8'd0, 0);
        do_req(1'b0, 30'h5, 32'h0, 8'd0, 0);
        do_req(1'b0, 30'h10, 32'h0, 8'd0, 5);
        do_req(1'b0, 30'h1000, 32'h0, 8'd0, 0);
        do_req(1'b1, 30'h1000, 32'hCAFE_F00D, 8'd0, 1);
        do_req(1'b1, 30'hFFF, 32'hA5A5_0FFF, 8'd0, 0);
        do_req(1'b0, 30'hFFE, 32'h0, 8'd3, 1);
        do_req(1'b0, 30'h3FFF_FFFF, 32'h0, 8'd2, 0);

        // Reset while waiting for read data: request abandoned.
        @(negedge clk);
        wc0 = web_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 30'h5; req_len = 8'd0;
        @(posedge clk); #1;          // now RD_ADDR
        req_valid = 1'b0;
        @(posedge clk); #1;          // now RD_WAIT
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid", 32'(resp_valid), 0);
        chk("abort_ready", 32'(req_ready), 1);
        rst_n = 1'b1;
        seen = 0;
        resp_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) seen++;
        end
        resp_ready = 1'b0;
        chk("abort_no_resp", 32'(seen), 0);
        chk("abort_no_web", 32'(web_cnt - wc0), 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            do_req(1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                   8'($urandom_range(0, 3)), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_mem_debug_master.md
INSTR_MEM_DEBUG_MASTER -- requirements
Module: instr_mem_debug_master

Interface
REQ-001 Parameter: none; all widths fixed (word address [31:2], data 32 bit, burst length 8 bit).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  30  word address [31:2].
REQ-008 req_wdata  input  32  write data.
REQ-009 req_len  input  8  extra read beats (burst length minus 1).
REQ-010 resp_valid  output  1  response beat present.
REQ-011 resp_ready  input  1  host accepts response beat.
REQ-012 resp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 resp_err  output  1  address outside 16 KiB window.
REQ-014 resp_last  output  1  final beat of the request.
REQ-015 ram_web  output  1  RAM port-b write enable.
REQ-016 ram_addrb  output  30  RAM port-b word address.
REQ-017 ram_dinb  output  32  RAM port-b write data.
REQ-018 ram_doutb  input  32  RAM port-b read data, valid one cycle after address.

Function
REQ-019 FSM states: IDLE, WRITE, RD_ADDR, RD_WAIT, RESP.
REQ-020 req_ready = 1 only in IDLE; handshake = req_valid & req_ready; request fields latched on handshake.
REQ-021 Valid address: addr[31:14] == 0; invalid access never asserts ram_web and returns resp_err=1, resp_rdata=0.
REQ-022 Write: IDLE -> WRITE; in WRITE, ram_web=1 for exactly one cycle (0 if invalid) with latched addr/data; -> RESP with resp_last=1.
REQ-023 Read: IDLE -> RD_ADDR (ram_addrb driven) -> RD_WAIT (ram_doutb captured into resp_rdata) -> RESP.
REQ-024 RESP: resp_valid=1 and outputs held stable until resp_ready; on handshake, if beats remain -> RD_ADDR with address+1, else -> IDLE.
REQ-025 Minimum latency: request handshake to resp_valid = 3 cycles for reads, 2 for writes.
REQ-026 ram_web = 0 in every state except WRITE.
REQ-027 Beat counter decrements per accepted read beat; resp_last=1 when counter = 0.
REQ-028 Burst address increments modulo 2^30; each beat checked independently for REQ-021 (wrap past window yields err beats, burst continues).
REQ-029 req_valid in non-IDLE states is ignored (no queueing).

Reset
REQ-030 rst_n=0 at a clock edge -> state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_last=0, ram_web=0, ram_addrb=0, ram_dinb=0, beat counter=0.
REQ-031 Reset mid-request aborts it; no further RAM write and no response for it.

Configuration
REQ-032 Macro DEBUG_BURST_EN: when defined, req_len honoured for reads per REQ-024/REQ-027.
REQ-033 Without DEBUG_BURST_EN: req_len ignored, every read is one beat, resp_last=1 on every response.
REQ-034 Writes are always single-beat regardless of macro.

Structure
REQ-035 Shared package holds FSM state encoding, window limit constant (addr[31:14]==0), and burst-length width.
REQ-036 No sub-module; single FSM plus counter and address register.

Verification
REQ-037 Write addr 0x00000010 data 0xDEADBEEF -> one-cycle ram_web=1, ram_addrb=0x10, ram_dinb=0xDEADBEEF; resp_valid 2 cycles later, err=0, last=1.
REQ-038 Read addr 0x00000005 after writing 0x12345678 there -> resp_rdata=0x12345678 3 cycles after handshake, err=0.
REQ-039 Read addr 0x00001000 (outside window) -> resp_err=1, resp_rdata=0, ram_web never 1.
REQ-040 DEBUG_BURST_EN, read addr 0x00000FFE len=3 -> beats 0x0FFE and 0x0FFF ok, 0x1000 and 0x1001 err, last only on 4th beat; without macro -> single beat, last=1.
REQ-041 resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata, resp_err stable; req_ready=0 throughout.
REQ-042 rst_n=0 during RD_WAIT -> next cycle IDLE, resp_valid=0, req_ready=1, no response emitted.
